// File: rtl/gcd_if.sv
// Operator/front-panel bundle for the subtractive GCD sequencer.
// The operator side drives Enter/Minput; the sequencer side drives the result and status.
interface gcd_if #(
  parameter int W = 8
);
  logic         Enter;
  logic [W-1:0] Minput;
  logic         Halt;
  logic [W-1:0] Moutput;
  logic         Busy;
  logic [W-1:0] IterCount;
  logic [3:0]   DisplayState;

  modport master (
    output Enter, Minput,
    input  Halt, Moutput, Busy, IterCount, DisplayState
  );

  modport slave (
    input  Enter, Minput,
    output Halt, Moutput, Busy, IterCount, DisplayState
  );
endinterface

// File: rtl/gcd_sequencer.sv
// Subtractive GCD controller: captures two operands on Enter presses, runs the
// subtract loop one step per clock and reports the result with front-panel status.
module gcd_sequencer #(
  parameter int W        = 8,
  parameter int MAX_ITER = 255
) (
  input  logic clock,
  input  logic reset,
  gcd_if.slave bus
);

  // State encodings double as the DisplayState front-panel codes.
  typedef enum logic [3:0] {
    IDLE  = 4'h0,
    WAITY = 4'h1,
    RUN   = 4'h2,
    DONE  = 4'h3,
    ERR   = 4'hF
  } state_t;

  localparam logic [W-1:0] ZERO_C     = {W{1'b0}};
  localparam logic [W-1:0] ONE_C      = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX_ITER_C = W'(MAX_ITER);

  state_t       state_r, state_s;
  logic [W-1:0] x_r, x_s;
  logic [W-1:0] y_r, y_s;
  logic [W-1:0] mout_r, mout_s;
  logic [W-1:0] iter_r, iter_s;
  logic         halt_r;
  logic         busy_r;
  logic         enter_q_r;
  logic         accept_s;

  // Next-state and datapath decisions for the sequencer.
  always_comb begin
    state_s  = state_r;
    x_s      = x_r;
    y_s      = y_r;
    mout_s   = mout_r;
    iter_s   = iter_r;
    accept_s = bus.Enter & ~enter_q_r;
    case (state_r)
      IDLE, DONE, ERR: begin
        if (accept_s) begin
          x_s     = bus.Minput;
          iter_s  = ZERO_C;
          state_s = WAITY;
        end else begin
          state_s = state_r;
        end
      end
      WAITY: begin
        if (accept_s) begin
          y_s     = bus.Minput;
          state_s = RUN;
        end else begin
          state_s = WAITY;
        end
      end
      RUN: begin
        // Terminating compares take priority over the iteration limit.
        if ((x_r == ZERO_C) || (y_r == ZERO_C)) begin
          mout_s  = x_r | y_r;
          state_s = DONE;
        end else if (x_r == y_r) begin
          mout_s  = x_r;
          state_s = DONE;
        end else if (iter_r == MAX_ITER_C) begin
          mout_s  = ZERO_C;
          state_s = ERR;
        end else if (x_r > y_r) begin
          x_s    = x_r - y_r;
          iter_s = iter_r + ONE_C;
        end else begin
          y_s    = y_r - x_r;
          iter_s = iter_r + ONE_C;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      x_r       <= ZERO_C;
      y_r       <= ZERO_C;
      mout_r    <= ZERO_C;
      iter_r    <= ZERO_C;
      halt_r    <= 1'b0;
      busy_r    <= 1'b0;
      enter_q_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      x_r       <= x_s;
      y_r       <= y_s;
      mout_r    <= mout_s;
      iter_r    <= iter_s;
      halt_r    <= (state_s == DONE) || (state_s == ERR);
      busy_r    <= (state_s == RUN);
      enter_q_r <= bus.Enter;
    end
  end

  assign bus.Halt         = halt_r;
  assign bus.Busy         = busy_r;
  assign bus.Moutput      = mout_r;
  assign bus.IterCount    = iter_r;
  assign bus.DisplayState = state_r;

endmodule

// File: tb/tb_gcd_sequencer.sv
// Randomized self-checking bench for gcd_sequencer against a Euclid-based model.
module tb_gcd_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enter = 1'b0;
  logic [7:0] minput = 8'd0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       halt_prev = 1'b0;
  logic [7:0] mout_prev = 8'd0;

  gcd_if #(.W(8)) ifa ();
  gcd_if #(.W(8)) ifb ();

  assign ifa.Enter  = enter;
  assign ifa.Minput = minput;
  assign ifb.Enter  = enter;
  assign ifb.Minput = minput;

  gcd_sequencer #(.W(8), .MAX_ITER(255)) dut (.clock(clock), .reset(reset), .bus(ifa.slave));
  gcd_sequencer #(.W(8), .MAX_ITER(10))  dut_lim (.clock(clock), .reset(reset), .bus(ifb.slave));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: gcd by Euclid; subtract steps = sum of quotients minus one.
  task automatic model(input int a, input int b, output int g, output int n);
    int p, q, r;
    if (a == 0 || b == 0) begin
      g = a | b;
      n = 0;
    end else begin
      p = a; q = b; n = 0;
      while (q != 0) begin
        n += p / q;
        r = p % q;
        p = q;
        q = r;
      end
      g = p;
      n -= 1;
    end
  endtask

  // Result may only change while Halt is low.
  always @(negedge clock) begin
    if (halt_prev && ifa.Halt) chk("mout_hold", 32'(ifa.Moutput), 32'(mout_prev));
    halt_prev = ifa.Halt;
    mout_prev = ifa.Moutput;
  end

  task automatic press(input logic [7:0] v);
    @(negedge clock);
    enter  = 1'b1;
    minput = v;
    @(negedge clock);
    enter  = 1'b0;
  endtask

  task automatic wait_done(input int a, input int b, input int elapsed);
    int g, n, cyc;
    model(a, b, g, n);
    cyc = elapsed;
    while (!ifa.Halt && cyc < 400) begin
      @(negedge clock);
      cyc++;
    end
    if (!ifa.Halt) chk("halt_timeout", 32'd0, 32'd1);
    chk("latency", 32'(cyc), 32'(n + 1));
    chk("moutput", 32'(ifa.Moutput), 32'(g));
    chk("itercount", 32'(ifa.IterCount), 32'(n));
    chk("disp_done", 32'(ifa.DisplayState), 32'd3);
    chk("busy_done", 32'(ifa.Busy), 32'd0);
  endtask

  task automatic run_pair(input int a, input int b);
    press(8'(a));
    chk("halt_drop", 32'(ifa.Halt), 32'd0);
    chk("disp_waity", 32'(ifa.DisplayState), 32'd1);
    press(8'(b));
    wait_done(a, b, 0);
  endtask

  initial begin
    int a, b;
    #12;
    chk("rst_halt", 32'(ifa.Halt), 32'd0);
    chk("rst_busy", 32'(ifa.Busy), 32'd0);
    chk("rst_mout", 32'(ifa.Moutput), 32'd0);
    chk("rst_iter", 32'(ifa.IterCount), 32'd0);
    chk("rst_disp", 32'(ifa.DisplayState), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    run_pair(12, 8);
    run_pair(7, 7);
    run_pair(0, 9);
    run_pair(0, 0);

    // Held Enter loads only X.
    @(negedge clock);
    enter  = 1'b1;
    minput = 8'd20;
    repeat (5) @(negedge clock);
    chk("hold_disp", 32'(ifa.DisplayState), 32'd1);
    enter = 1'b0;
    press(8'd15);
    wait_done(20, 15, 0);

    // Enter pulse during RUN is ignored.
    press(8'd100);
    press(8'd7);
    chk("busy_run", 32'(ifa.Busy), 32'd1);
    chk("disp_run", 32'(ifa.DisplayState), 32'd2);
    enter  = 1'b1;
    minput = 8'd3;
    @(negedge clock);
    enter = 1'b0;
    @(negedge clock);
    wait_done(100, 7, 2);

    // Reset mid-run clears everything immediately.
    press(8'd100);
    press(8'd3);
    repeat (4) @(negedge clock);
    chk("mid_iter", 32'(ifa.IterCount), 32'd4);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(ifa.Busy), 32'd0);
    chk("arst_iter", 32'(ifa.IterCount), 32'd0);
    chk("arst_mout", 32'(ifa.Moutput), 32'd0);
    chk("arst_disp", 32'(ifa.DisplayState), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_pair(6, 4);

    // Worst case; the MAX_ITER=10 instance must abort to ERR.
    run_pair(127, 1);
    chk("lim_disp", 32'(ifb.DisplayState), 32'hF);
    chk("lim_halt", 32'(ifb.Halt), 32'd1);
    chk("lim_mout", 32'(ifb.Moutput), 32'd0);
    chk("lim_iter", 32'(ifb.IterCount), 32'd10);
    chk("lim_busy", 32'(ifb.Busy), 32'd0);

    for (int i = 0; i < 100; i++) begin
      a = int'($urandom_range(127, 1));
      b = int'($urandom_range(127, 1));
      run_pair(a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
